// File: rtl/spi_adc_pkg.sv
// Shared constants and state encoding for the ADC128S022-style SPI responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_adc_pkg;

   // SCLK rising edges per frame, and the number of zero bits ahead of the sample
   localparam logic [4:0] FRAME_LEN     = 5'd16;
   localparam int         LEAD_ZEROS    = 4;

   // DIN is captured while the pre-increment rise count is in this range (MSB first)
   localparam logic [4:0] ADDR_LSB_RISE = 5'd2;
   localparam logic [4:0] ADDR_MSB_RISE = 5'd4;

   localparam int         CH_W          = 3;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      SHIFT
   } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Synchronizer for one asynchronous pin with single-cycle edge pulses.
// Latency: an edge pulse appears SYNC_STAGES cycles after the pin changes; it is acted on one cycle later.
// Backpressure: none.
// Ports: clk/rst (sync, active high); d = raw pin; rise/fall = one-cycle edge pulses.
module spi_in_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   hist;

   // Reset to the pin's idle level so leaving reset does not fake an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= {SYNC_STAGES{RST_VAL}};
         hist <= RST_VAL;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
         hist <= sync[SYNC_STAGES-1];
      end
   end

   assign rise =  sync[SYNC_STAGES-1] & ~hist;
   assign fall = ~sync[SYNC_STAGES-1] &  hist;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating the ADC128S022: decodes a 3-bit channel address, returns 4 zeros + sample MSB first.
// Latency: pins are seen SYNC_STAGES+1 clk cycles after they change; DOUT updates that many cycles after SCLK falls.
// Backpressure: none; the initiator owns timing, clk must be at least 8x SCLK.
// Ports: SPI pins SCLK/CS_N/DIN/DOUT(+dout_oe); host bank write wr_en/wr_addr/wr_data;
//        frame status frame_done/ch_sent/data_sent, frame_err on early CS_N release, next_ch = pending address.
module spi_adc_responder
   import spi_adc_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = 12,
   parameter int NUM_CH      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SCLK,
   input  logic              CS_N,
   input  logic              DIN,
   output logic              DOUT,
   output logic              dout_oe,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              frame_done,
   output logic [CH_W-1:0]   ch_sent,
   output logic [DATA_W-1:0] data_sent,
   output logic [CH_W-1:0]   next_ch,
   output logic              frame_err
);

   localparam int SR_W = LEAD_ZEROS + DATA_W;

   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] din_sync;
   logic                   din_q;

   logic [DATA_W-1:0]      ch_reg [NUM_CH];

   state_t                 state;
   logic [4:0]             rise_cnt;
   logic [SR_W-1:0]        shift;
   logic [CH_W-1:0]        cur_ch;
   logic [CH_W-1:0]        addr_sr;
   logic [DATA_W-1:0]      cur_data;
   logic                   reload;

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (SCLK),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (CS_N),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   // DIN needs no edge detect; its last stage lines up with the SCLK edge pulses
   always_ff @(posedge clk) begin
      if (rst) din_sync <= '0;
      else     din_sync <= {din_sync[SYNC_STAGES-2:0], DIN};
   end
   assign din_q = din_sync[SYNC_STAGES-1];

   // A load in the same cycle as a write reads the old value naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) ch_reg[i] <= '0;
      end else if (wr_en) begin
         ch_reg[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rise_cnt   <= '0;
         shift      <= '0;
         cur_ch     <= '0;
         cur_data   <= '0;
         addr_sr    <= '0;
         reload     <= 1'b0;
         DOUT       <= 1'b0;
         dout_oe    <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         ch_sent    <= '0;
         data_sent  <= '0;
         next_ch    <= '0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  shift    <= {{LEAD_ZEROS{1'b0}}, ch_reg[next_ch]};
                  cur_data <= ch_reg[next_ch];
                  cur_ch   <= next_ch;
                  DOUT     <= 1'b0;
                  dout_oe  <= 1'b1;
                  rise_cnt <= '0;
                  reload   <= 1'b0;
                  state    <= ARMED;
               end
            end
            ARMED, SHIFT: begin
               // CS_N release has priority over any SCLK edge in the same cycle
               if (cs_rise) begin
                  DOUT    <= 1'b0;
                  dout_oe <= 1'b0;
                  reload  <= 1'b0;
                  state   <= IDLE;
                  if (rise_cnt != '0) frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  rise_cnt <= rise_cnt + 5'd1;
                  state    <= SHIFT;
                  if (rise_cnt >= ADDR_LSB_RISE && rise_cnt <= ADDR_MSB_RISE)
                     addr_sr <= {addr_sr[CH_W-2:0], din_q};
                  if (rise_cnt == FRAME_LEN - 5'd1) begin
                     frame_done <= 1'b1;
                     ch_sent    <= cur_ch;
                     data_sent  <= cur_data;
                     next_ch    <= addr_sr;
                     rise_cnt   <= '0;
                     reload     <= 1'b1;
                  end
               end else if (sclk_fall && state == SHIFT) begin
                  // ARMED ignores falling edges, including SCLK's first drop from idle-high
                  if (reload) begin
                     shift    <= {{LEAD_ZEROS{1'b0}}, ch_reg[next_ch]};
                     cur_data <= ch_reg[next_ch];
                     cur_ch   <= next_ch;
                     DOUT     <= 1'b0;
                     reload   <= 1'b0;
                     state    <= ARMED;
                  end else if (rise_cnt != '0) begin
                     shift <= {shift[SR_W-2:0], 1'b0};
                     DOUT  <= shift[SR_W-2];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Self-checking bench for spi_adc_responder: drives SPI frames at clk/20 and checks against a channel-bank model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_adc_responder;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        SCLK, CS_N, DIN;
   logic        DOUT, dout_oe;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [11:0] wr_data;
   logic        frame_done, frame_err;
   logic [2:0]  ch_sent, next_ch;
   logic [11:0] data_sent;

   int total = 0;
   int bad   = 0;

   // pulse monitor
   int          done_cnt = 0;
   int          err_cnt  = 0;
   logic [2:0]  cap_ch   = '0;
   logic [11:0] cap_data = '0;

   // reference model: channel bank and the address pending for the next frame
   logic [11:0] model_reg [8];
   logic [2:0]  model_next;

   spi_adc_responder #(.SYNC_STAGES(SYNC), .DATA_W(12), .NUM_CH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .SCLK       (SCLK),
      .CS_N       (CS_N),
      .DIN        (DIN),
      .DOUT       (DOUT),
      .dout_oe    (dout_oe),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .ch_sent    (ch_sent),
      .data_sent  (data_sent),
      .next_ch    (next_ch),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1) begin
         done_cnt++;
         cap_ch   = ch_sent;
         cap_data = data_sent;
      end
      if (frame_err === 1'b1) err_cnt++;
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) model_reg[i] = 12'h000;
      model_next = 3'd0;
   endtask

   task automatic host_write(input logic [2:0] a, input logic [11:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      model_reg[a] = d;
   endtask

   // Drives n SCLK rising edges under one CS_N low period (SCLK half period 100ns).
   // Address a0 goes on rising edges 3..5 of the first 16, a1 on those of the next 16.
   // bits/oe collect DOUT and dout_oe as seen at each rising edge, first edge in the MSB.
   // coll: write cdata to the pending channel in the cycle the CS_N fall is acted on.
   task automatic spi_run(input int n, input logic [2:0] a0, input logic [2:0] a1,
                          input bit coll, input logic [11:0] cdata,
                          output logic [31:0] bits, output logic [31:0] oe);
      bits = '0;
      oe   = '0;
      @(negedge clk);
      CS_N = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (coll && c == SYNC) begin
            wr_en = 1'b1; wr_addr = model_next; wr_data = cdata;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
      end
      wr_en = 1'b0;
      for (int k = 1; k <= n; k++) begin
         int         j;
         logic [2:0] a;
         j = (k - 1) % 16 + 1;
         a = ((k - 1) / 16 == 0) ? a0 : a1;
         SCLK = 1'b0;
         if (j >= 3 && j <= 5) DIN = a[5 - j];
         else                  DIN = 1'($urandom);
         #100;
         bits = {bits[30:0], DOUT};
         oe   = {oe[30:0], dout_oe};
         SCLK = 1'b1;
         #100;
      end
      CS_N = 1'b1;
      DIN  = 1'b0;
      #100;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (DOUT !== 1'b0)          begin bad++; $display("FAIL reset_dout got %b want 0", DOUT); end
      total++; if (dout_oe !== 1'b0)       begin bad++; $display("FAIL reset_oe got %b want 0", dout_oe); end
      total++; if (frame_done !== 1'b0)    begin bad++; $display("FAIL reset_done got %b want 0", frame_done); end
      total++; if (frame_err !== 1'b0)     begin bad++; $display("FAIL reset_err got %b want 0", frame_err); end
      total++; if (ch_sent !== 3'd0)       begin bad++; $display("FAIL reset_ch_sent got %h want 0", ch_sent); end
      total++; if (data_sent !== 12'h000)  begin bad++; $display("FAIL reset_data_sent got %h want 0", data_sent); end
      total++; if (next_ch !== 3'd0)       begin bad++; $display("FAIL reset_next_ch got %h want 0", next_ch); end
      rst = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic();
      logic [31:0] bits, oe;
      logic [2:0]  addrs [2];
      int          d0, e0;
      addrs[0] = 3'd5;
      addrs[1] = 3'd2;
      for (int i = 0; i < 8; i++) host_write(3'(i), 12'h100 + 12'(i));
      for (int f = 0; f < 2; f++) begin
         logic [2:0]  exp_ch;
         logic [11:0] exp_d;
         exp_ch = model_next;
         exp_d  = model_reg[model_next];
         d0 = done_cnt; e0 = err_cnt;
         spi_run(16, addrs[f], 3'd0, 1'b0, 12'h0, bits, oe);
         total++; if (bits[15:0] !== {4'h0, exp_d}) begin bad++; $display("FAIL basic_bits f%0d got %h want %h", f, bits[15:0], {4'h0, exp_d}); end
         total++; if (done_cnt - d0 != 1)           begin bad++; $display("FAIL basic_done_count f%0d got %0d want 1", f, done_cnt - d0); end
         total++; if (err_cnt - e0 != 0)            begin bad++; $display("FAIL basic_err_count f%0d got %0d want 0", f, err_cnt - e0); end
         total++; if (cap_ch !== exp_ch)            begin bad++; $display("FAIL basic_ch_sent f%0d got %h want %h", f, cap_ch, exp_ch); end
         total++; if (cap_data !== exp_d)           begin bad++; $display("FAIL basic_data_sent f%0d got %h want %h", f, cap_data, exp_d); end
         total++; if (next_ch !== addrs[f])         begin bad++; $display("FAIL basic_next_ch f%0d got %h want %h", f, next_ch, addrs[f]); end
         model_next = addrs[f];
      end
   endtask

   task automatic test_bits();
      logic [31:0] bits, oe;
      logic [2:0]  a;
      host_write(model_next, 12'hA5C);
      a = 3'($urandom);
      spi_run(16, a, 3'd0, 1'b0, 12'h0, bits, oe);
      total++; if (bits[15:0] !== 16'b0000_1010_0101_1100) begin bad++; $display("FAIL bits_a5c got %b want 0000101001011100", bits[15:0]); end
      total++; if (oe[15:0] !== 16'hFFFF) begin bad++; $display("FAIL bits_oe_in_frame got %h want ffff", oe[15:0]); end
      total++; if (dout_oe !== 1'b0)      begin bad++; $display("FAIL bits_oe_after_cs got %b want 0", dout_oe); end
      model_next = a;
   endtask

   task automatic test_abort();
      logic [31:0] bits, oe;
      logic [2:0]  prev, a;
      logic [11:0] exp_d;
      int          d0, e0;
      prev = model_next;
      a    = prev + 3'd3;
      d0 = done_cnt; e0 = err_cnt;
      spi_run(7, a, 3'd0, 1'b0, 12'h0, bits, oe);
      total++; if (err_cnt - e0 != 1)  begin bad++; $display("FAIL abort_err_pulse got %0d cycles want 1", err_cnt - e0); end
      total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", done_cnt - d0); end
      total++; if (next_ch !== prev)   begin bad++; $display("FAIL abort_next_ch got %h want %h", next_ch, prev); end
      total++; if (dout_oe !== 1'b0)   begin bad++; $display("FAIL abort_oe got %b want 0", dout_oe); end
      exp_d = model_reg[prev];
      d0 = done_cnt; e0 = err_cnt;
      spi_run(16, a, 3'd0, 1'b0, 12'h0, bits, oe);
      total++; if (bits[15:0] !== {4'h0, exp_d}) begin bad++; $display("FAIL abort_resend got %h want %h", bits[15:0], {4'h0, exp_d}); end
      total++; if (cap_ch !== prev)              begin bad++; $display("FAIL abort_resend_ch got %h want %h", cap_ch, prev); end
      total++; if (err_cnt - e0 != 0)            begin bad++; $display("FAIL abort_resend_err got %0d want 0", err_cnt - e0); end
      model_next = a;
   endtask

   task automatic test_continuous();
      logic [31:0] bits, oe;
      logic [11:0] exp0, exp1;
      int          d0, e0;
      exp0 = model_reg[model_next];
      exp1 = model_reg[3];
      d0 = done_cnt; e0 = err_cnt;
      spi_run(32, 3'd3, 3'd6, 1'b0, 12'h0, bits, oe);
      total++; if (done_cnt - d0 != 2)             begin bad++; $display("FAIL cont_done_count got %0d want 2", done_cnt - d0); end
      total++; if (err_cnt - e0 != 0)              begin bad++; $display("FAIL cont_err_count got %0d want 0", err_cnt - e0); end
      total++; if (bits[31:16] !== {4'h0, exp0})   begin bad++; $display("FAIL cont_frame1 got %h want %h", bits[31:16], {4'h0, exp0}); end
      total++; if (bits[15:0] !== {4'h0, exp1})    begin bad++; $display("FAIL cont_frame2 got %h want %h", bits[15:0], {4'h0, exp1}); end
      total++; if (cap_ch !== 3'd3)                begin bad++; $display("FAIL cont_ch_sent got %h want 3", cap_ch); end
      total++; if (cap_data !== exp1)              begin bad++; $display("FAIL cont_data_sent got %h want %h", cap_data, exp1); end
      total++; if (next_ch !== 3'd6)               begin bad++; $display("FAIL cont_next_ch got %h want 6", next_ch); end
      total++; if (oe !== 32'hFFFF_FFFF)           begin bad++; $display("FAIL cont_oe got %h want ffffffff", oe); end
      model_next = 3'd6;
   endtask

   task automatic test_collision();
      logic [31:0] bits, oe;
      logic [2:0]  ch;
      ch = model_next;
      host_write(ch, 12'h3C3);
      spi_run(16, ch, 3'd0, 1'b1, 12'hFFF, bits, oe);
      total++; if (bits[15:0] !== 16'h03C3) begin bad++; $display("FAIL coll_old_value got %h want 03c3", bits[15:0]); end
      model_reg[ch] = 12'hFFF;
      spi_run(16, ch, 3'd0, 1'b0, 12'h0, bits, oe);
      total++; if (bits[15:0] !== 16'h0FFF) begin bad++; $display("FAIL coll_new_value got %h want 0fff", bits[15:0]); end
      total++; if (cap_data !== 12'hFFF)    begin bad++; $display("FAIL coll_data_sent got %h want fff", cap_data); end
   endtask

   task automatic test_random();
      logic [31:0] bits, oe;
      for (int it = 0; it < 6; it++) begin
         int          nw;
         int          d0;
         logic [2:0]  a, exp_ch;
         logic [11:0] exp_d;
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++) host_write(3'($urandom), 12'($urandom));
         a      = 3'($urandom);
         exp_ch = model_next;
         exp_d  = model_reg[model_next];
         d0     = done_cnt;
         spi_run(16, a, 3'd0, 1'b0, 12'h0, bits, oe);
         total++; if (bits[15:0] !== {4'h0, exp_d}) begin bad++; $display("FAIL rand_bits it%0d got %h want %h", it, bits[15:0], {4'h0, exp_d}); end
         total++; if (done_cnt - d0 != 1)           begin bad++; $display("FAIL rand_done it%0d got %0d want 1", it, done_cnt - d0); end
         total++; if (cap_ch !== exp_ch)            begin bad++; $display("FAIL rand_ch_sent it%0d got %h want %h", it, cap_ch, exp_ch); end
         total++; if (next_ch !== a)                begin bad++; $display("FAIL rand_next_ch it%0d got %h want %h", it, next_ch, a); end
         model_next = a;
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] bits, oe;
      int          e0;
      host_write(model_next, 12'h777);
      e0 = err_cnt;
      @(negedge clk);
      CS_N = 1'b0;
      repeat (10) @(negedge clk);
      for (int k = 1; k <= 9; k++) begin
         SCLK = 1'b0;
         DIN  = 1'($urandom);
         #100;
         SCLK = 1'b1;
         if (k < 9) #100;
      end
      #40;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (DOUT !== 1'b0)    begin bad++; $display("FAIL rstmid_dout got %b want 0", DOUT); end
      total++; if (dout_oe !== 1'b0) begin bad++; $display("FAIL rstmid_oe got %b want 0", dout_oe); end
      total++; if (next_ch !== 3'd0) begin bad++; $display("FAIL rstmid_next_ch got %h want 0", next_ch); end
      CS_N = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (10) @(negedge clk);
      total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL rstmid_no_err got %0d want 0", err_cnt - e0); end
      spi_run(16, 3'd1, 3'd0, 1'b0, 12'h0, bits, oe);
      total++; if (bits[15:0] !== 16'h0000) begin bad++; $display("FAIL rstmid_fresh_frame got %h want 0000", bits[15:0]); end
      total++; if (cap_ch !== 3'd0)         begin bad++; $display("FAIL rstmid_fresh_ch got %h want 0", cap_ch); end
      total++; if (next_ch !== 3'd1)        begin bad++; $display("FAIL rstmid_fresh_next got %h want 1", next_ch); end
   endtask

   initial begin
      rst     = 1'b1;
      SCLK    = 1'b1;
      CS_N    = 1'b1;
      DIN     = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      model_reset();
      test_reset();
      test_basic();
      test_bits();
      test_abort();
      test_continuous();
      test_collision();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
